key_debounce: RTL and testbench

Button input conditioner for the board's active-low push keys. It synchronises each raw `key_n` line into the `clk` domain and debounces it with a per-key counter and state machine. It presents clean debounced levels, single-cycle press/release strobes and a press-toggled state. It sits between the key pins and the LED/button control logic, which consumes `key_press`/`key_toggle` in place of sampling raw key edges.

---
 rtl/key_debounce.sv | 150 +++++++++++++++
 tb/tb_key_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: conditions the board's active-low push keys.
// Each key has its own two-flop synchroniser, a debounce counter and a
// four-state FSM (UP / PEND_DOWN / DOWN / PEND_UP). A level change is accepted
// only after the synchronised input holds the new value for DEBOUNCE_CYCLES
// consecutive clocks. The block presents a registered debounced level,
// one-cycle press/release strobes and a press-toggled bit per key.
// There is no valid/ready handshake: every output is a plain registered level
// or a one-cycle strobe, valid on every clock outside reset.
module key_debounce #(
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NKEYS-1:0] key_n,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_toggle
);

   typedef enum logic [1:0] {
      UP        = 2'd0,
      PEND_DOWN = 2'd1,
      DOWN      = 2'd2,
      PEND_UP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Per-key FSM state, kept as a named array so checkers can bind to it.
   state_t           state     [NKEYS];
   state_t           state_nxt [NKEYS];
   logic [CNT_W-1:0] cnt       [NKEYS];
   logic [CNT_W-1:0] cnt_nxt   [NKEYS];

   logic [NKEYS-1:0] sync1;
   logic [NKEYS-1:0] sync2;
   logic [NKEYS-1:0] s;

   logic [NKEYS-1:0] accept_dn;
   logic [NKEYS-1:0] accept_up;
   logic [NKEYS-1:0] level_nxt;
   logic [NKEYS-1:0] press_nxt;
   logic [NKEYS-1:0] release_nxt;
   logic [NKEYS-1:0] toggle_nxt;

   // Two-flop synchroniser; resets to the released level (key_n high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Synchronised key, 1 = pressed.
   assign s = ~sync2;

   // State register: FSM state and debounce counter per key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NKEYS; i++) begin
            state[i] <= UP;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NKEYS; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
      end
   end

   // Next-state logic: a pending state restarts from its stable state on any
   // bounce, so the count always measures consecutive stable cycles.
   always_comb begin
      for (int i = 0; i < NKEYS; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = '0;
         case (state[i])
            UP: begin
               if (s[i]) begin
                  state_nxt[i] = PEND_DOWN;
                  cnt_nxt[i]   = CNT_ONE;
               end
            end
            PEND_DOWN: begin
               if (!s[i]) begin
                  state_nxt[i] = UP;
               end else if (cnt[i] == CNT_LAST) begin
                  state_nxt[i] = DOWN;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            DOWN: begin
               if (!s[i]) begin
                  state_nxt[i] = PEND_UP;
                  cnt_nxt[i]   = CNT_ONE;
               end
            end
            PEND_UP: begin
               if (s[i]) begin
                  state_nxt[i] = DOWN;
               end else if (cnt[i] == CNT_LAST) begin
                  state_nxt[i] = UP;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            default: begin
               state_nxt[i] = UP;
            end
         endcase
      end
   end

   // Output logic: acceptance edges drive next values of the registered outputs.
   always_comb begin
      for (int i = 0; i < NKEYS; i++) begin
         accept_dn[i] = (state[i] == PEND_DOWN) && s[i] && (cnt[i] == CNT_LAST);
         accept_up[i] = (state[i] == PEND_UP) && !s[i] && (cnt[i] == CNT_LAST);
      end
      press_nxt   = accept_dn;
      release_nxt = accept_up;
      level_nxt   = (key_level | accept_dn) & ~accept_up;
      toggle_nxt  = key_toggle ^ accept_dn;
   end

   // Output registers: no combinational path from key_n to any output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_toggle  <= '0;
      end else begin
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_toggle  <= toggle_nxt;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with DEBOUNCE_CYCLES=8.
// A behavioural model (delay line + run-length of disagreement with the
// accepted level) predicts all outputs every cycle; directed sequences add
// hand-computed literal expectations on latency, strobe counts and toggles.
`timescale 1ns/1ps
module tb_key_debounce;

   localparam int NKEYS = 4;
   localparam int DB    = 8;
   localparam int CW    = 20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NKEYS-1:0] key_n = '1;
   logic [NKEYS-1:0] key_level, key_press, key_release, key_toggle;

   always #5 clk = ~clk;

   key_debounce #(.NKEYS(NKEYS), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_toggle(key_toggle)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   // Raw samples pass through a two-deep delay line; a key's accepted level
   // flips once the delayed sample has disagreed with it for DB straight cycles.
   logic [NKEYS-1:0] m_d1 = '1;
   logic [NKEYS-1:0] m_d2 = '1;
   logic [NKEYS-1:0] m_level = '0;
   logic [NKEYS-1:0] m_press = '0;
   logic [NKEYS-1:0] m_release = '0;
   logic [NKEYS-1:0] m_toggle = '0;
   int run [NKEYS] = '{default: 0};

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_d1 = '1; m_d2 = '1;
         m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
         for (int k = 0; k < NKEYS; k++) run[k] = 0;
      end else begin
         for (int k = 0; k < NKEYS; k++) begin
            logic pressed;
            pressed = ~m_d2[k];
            m_press[k] = 1'b0;
            m_release[k] = 1'b0;
            if (pressed != m_level[k]) run[k] = run[k] + 1;
            else run[k] = 0;
            if (run[k] == DB) begin
               run[k] = 0;
               m_level[k] = pressed;
               if (pressed) begin
                  m_press[k] = 1'b1;
                  m_toggle[k] = ~m_toggle[k];
               end else begin
                  m_release[k] = 1'b1;
               end
            end
         end
         m_d2 = m_d1;
         m_d1 = key_n;
      end
   end

   // ---------------- per-cycle compare + strobe monitor ----------------
   int press_cnt [NKEYS] = '{default: 0};
   int rel_cnt   [NKEYS] = '{default: 0};
   int press_cyc [NKEYS] = '{default: 0};
   int rel_cyc   [NKEYS] = '{default: 0};

   initial forever begin
      @(negedge clk);
      check("model_level", 32'(key_level), 32'(m_level));
      check("model_press", 32'(key_press), 32'(m_press));
      check("model_release", 32'(key_release), 32'(m_release));
      check("model_toggle", 32'(key_toggle), 32'(m_toggle));
      for (int k = 0; k < NKEYS; k++) begin
         if (key_press[k]) begin
            press_cnt[k]++;
            press_cyc[k] = cyc;
         end
         if (key_release[k]) begin
            rel_cnt[k]++;
            rel_cyc[k] = cyc;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequences ----------------
   initial begin
      int p0, r0, fall_cyc;

      // Reset values
      key_n = 4'hF;
      tick(2);
      do_reset();
      for (int i = 0; i < 50; i++) begin
         tick(1);
         #1;
         check("reset_outputs_zero", {key_level, key_press, key_release, key_toggle}, 32'h0);
      end

      // Clean press on key 0: strobe on the 10th edge after the step
      key_n[0] = 1'b0;
      tick(9);
      #1 check("clean_press_early", 32'(key_press), 32'h0);
      tick(1);
      #1 check("clean_press_strobe", 32'(key_press), 32'h1);
      check("clean_press_level", 32'(key_level), 32'h1);
      check("clean_press_toggle", 32'(key_toggle), 32'h1);
      tick(1);
      #1 check("clean_press_one_cycle", 32'(key_press), 32'h0);
      check("clean_press_level_held", 32'(key_level[0]), 32'h1);

      // Glitch rejection on key 1
      p0 = press_cnt[1];
      key_n[1] = 1'b0;
      tick(7);
      key_n[1] = 1'b1;
      tick(20);
      check("glitch7_no_press", 32'(press_cnt[1] - p0), 32'h0);
      check("glitch7_level", 32'(key_level[1]), 32'h0);
      p0 = press_cnt[1];
      r0 = rel_cnt[1];
      key_n[1] = 1'b0;
      tick(8);
      key_n[1] = 1'b1;
      tick(30);
      check("pulse8_one_press", 32'(press_cnt[1] - p0), 32'h1);
      check("pulse8_one_release", 32'(rel_cnt[1] - r0), 32'h1);
      check("pulse8_spacing_ge8", 32'((rel_cyc[1] - press_cyc[1]) >= DB), 32'h1);

      // Bouncing press on key 2: runs 3 low, 2 high, 5 low, 1 high, then hold
      p0 = press_cnt[2];
      key_n[2] = 1'b0; tick(3);
      key_n[2] = 1'b1; tick(2);
      key_n[2] = 1'b0; tick(5);
      key_n[2] = 1'b1; tick(1);
      key_n[2] = 1'b0;
      fall_cyc = cyc;
      tick(25);
      check("bounce_one_press", 32'(press_cnt[2] - p0), 32'h1);
      check("bounce_latency", 32'(press_cyc[2] - fall_cyc), 32'd10);

      // Simultaneous keys from a fresh reset so toggles start at 0
      key_n = 4'hF;
      tick(20);
      do_reset();
      tick(5);
      for (int rep = 0; rep < 2; rep++) begin
         key_n = 4'h0;
         tick(10);
         #1 check("simul_press", 32'(key_press), 32'hF);
         check("simul_toggle", 32'(key_toggle), (rep == 0) ? 32'hF : 32'h0);
         tick(10);
         key_n = 4'hF;
         tick(10);
         #1 check("simul_release", 32'(key_release), 32'hF);
         check("simul_level_low", 32'(key_level), 32'h0);
         tick(10);
      end

      // Reset mid-operation on key 3 while key 0 is held down
      key_n = 4'b1110;
      tick(20);
      check("pre_reset_level", 32'(key_level), 32'h1);
      key_n = 4'b0110;
      tick(7);
      rst_n = 1'b0;
      #1 check("async_reset_outputs", {key_level, key_press, key_release, key_toggle}, 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(9);
      #1 check("post_reset_early", 32'(key_press), 32'h0);
      tick(1);
      #1 check("post_reset_press", 32'(key_press), 32'h9);
      check("post_reset_toggle", 32'(key_toggle), 32'h9);
      tick(10);
      key_n = 4'hF;
      tick(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
